// File: rtl/sync_gray_ptr.sv
// N-stage Gray-pointer synchroniser for the destination clock domain.
// Provides a registered binary copy, a change strobe and Gray-violation tracking.
// Optional build macro SYNC_GRAY_HOLD_EN discards samples that fail the Gray check.
module sync_gray_ptr #(
  parameter int unsigned PTR_WIDTH     = 5,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     dst_clk,
  input  logic                     rst,
  input  logic [PTR_WIDTH-1:0]     ptr_gray_in,
  input  logic                     err_clr,
  output logic [PTR_WIDTH-1:0]     ptr_gray_sync,
  output logic [PTR_WIDTH-1:0]     ptr_bin_sync,
  output logic                     ptr_changed,
  output logic                     sync_valid,
  output logic                     gray_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_gray_ptr: SYNC_STAGES must be in 2..4");
  end
  if (PTR_WIDTH < 2 || PTR_WIDTH > 32) begin : g_bad_width
    $error("sync_gray_ptr: PTR_WIDTH must be in 2..32");
  end

  localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][PTR_WIDTH-1:0] r_sync;
  logic [PTR_WIDTH-1:0]                  r_gray;
  logic [PTR_WIDTH-1:0]                  r_bin;
  logic                                  r_changed;
  logic                                  r_valid;
  logic [WARM_W-1:0]                     r_warm;
  logic                                  r_err;
  logic [ERR_CNT_WIDTH-1:0]              r_cnt;

  logic [PTR_WIDTH-1:0] w_last;
  logic [PTR_WIDTH-1:0] w_diff;
  logic [PTR_WIDTH-1:0] w_bin;
  logic                 w_viol;
  logic                 w_accept;

  assign w_last = r_sync[SYNC_STAGES-1];
  assign w_diff = w_last ^ r_gray;

  // Clearing the lowest set bit leaves something only if two or more bits differ.
  assign w_viol = r_valid && ((w_diff & (w_diff - PTR_WIDTH'(1))) != '0);

  always_comb begin
    w_bin = '0;
    for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
      w_bin[i] = ^(w_last >> i);
    end
  end

`ifdef SYNC_GRAY_HOLD_EN
  assign w_accept = !w_viol;
`else
  assign w_accept = 1'b1;
`endif

  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ptr_gray_in};
    end
  end

  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) begin
      r_warm  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_warm != WARM_W'(SYNC_STAGES)) begin
        r_warm <= r_warm + WARM_W'(1);
      end else begin
        r_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) begin
      r_gray    <= '0;
      r_bin     <= '0;
      r_changed <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gray <= w_last;
        r_bin  <= w_bin;
      end
      r_changed <= r_valid && (w_diff != '0) && w_accept;
    end
  end

  // A violation in the same cycle as err_clr restarts the count at one.
  always_ff @(posedge dst_clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_viol) begin
      r_err <= 1'b1;
      if (err_clr) begin
        r_cnt <= ERR_CNT_WIDTH'(1);
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + ERR_CNT_WIDTH'(1);
      end
    end else if (err_clr) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end
  end

  assign ptr_gray_sync = r_gray;
  assign ptr_bin_sync  = r_bin;
  assign ptr_changed   = r_changed;
  assign sync_valid    = r_valid;
  assign gray_err      = r_err;
  assign err_count     = r_cnt;

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Directed bench for sync_gray_ptr: warm-up, latency, wrap, violations, clear, reset.
module tb_sync_gray_ptr;

  logic       dst_clk = 1'b0;
  logic       rst;
  logic [4:0] ptr_gray_in;
  logic       err_clr;
  logic [4:0] ptr_gray_sync;
  logic [4:0] ptr_bin_sync;
  logic       ptr_changed;
  logic       sync_valid;
  logic       gray_err;
  logic [1:0] err_count;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_prev;

  typedef struct {
    logic [4:0] gin;
    logic [4:0] egray;
    logic [4:0] ebin;
    logic       echg;
  } vec_t;

  vec_t tbl[4];

  sync_gray_ptr #(
    .PTR_WIDTH    (5),
    .SYNC_STAGES  (2),
    .ERR_CNT_WIDTH(2)
  ) dut (
    .dst_clk      (dst_clk),
    .rst          (rst),
    .ptr_gray_in  (ptr_gray_in),
    .err_clr      (err_clr),
    .ptr_gray_sync(ptr_gray_sync),
    .ptr_bin_sync (ptr_bin_sync),
    .ptr_changed  (ptr_changed),
    .sync_valid   (sync_valid),
    .gray_err     (gray_err),
    .err_count    (err_count)
  );

  always #5 dst_clk = ~dst_clk;

  task automatic tick();
    @(posedge dst_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a new input, confirm it is not visible after 2 edges, visible after 3,
  // and that the change strobe lasts exactly one cycle.
  task automatic step(input logic [4:0] gin, input logic [4:0] eg, input logic [4:0] eb,
                      input logic ech);
    ptr_gray_in = gin;
    tick();
    tick();
    chk("latency_hold", ptr_gray_sync, exp_prev);
    tick();
    chk("gray_out", ptr_gray_sync, eg);
    chk("bin_out", ptr_bin_sync, eb);
    chk("chg_pulse", ptr_changed, ech);
    tick();
    chk("chg_drop", ptr_changed, 1'b0);
    exp_prev = eg;
  endtask

  task automatic do_reset(input logic [4:0] gin);
    rst = 1'b1;
    ptr_gray_in = gin;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] b;
    logic [4:0] g;

    tbl[0] = '{gin: 5'b00000, egray: 5'b00000, ebin: 5'd0, echg: 1'b0};
    tbl[1] = '{gin: 5'b00001, egray: 5'b00001, ebin: 5'd1, echg: 1'b1};
    tbl[2] = '{gin: 5'b00011, egray: 5'b00011, ebin: 5'd2, echg: 1'b1};
    tbl[3] = '{gin: 5'b00010, egray: 5'b00010, ebin: 5'd3, echg: 1'b1};

    err_clr = 1'b0;
    ptr_gray_in = '0;
    rst = 1'b1;
    #2;
    chk("rst_gray", ptr_gray_sync, 5'b0);
    chk("rst_valid", sync_valid, 1'b0);
    chk("rst_err", gray_err, 1'b0);
    chk("rst_cnt", err_count, 2'd0);

    // Warm-up
    do_reset(5'b00110);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("warm_valid", sync_valid, (e == 3) ? 1'b1 : 1'b0);
      chk("warm_chg", ptr_changed, 1'b0);
    end
    chk("warm_gray", ptr_gray_sync, 5'b00110);
    chk("warm_bin", ptr_bin_sync, 5'b00100);
    tick();
    chk("warm_chg_after", ptr_changed, 1'b0);

    // Latency / conversion table, from a fresh reset at zero
    do_reset(5'b00000);
    for (int e = 0; e < 4; e++) tick();
    chk("valid_again", sync_valid, 1'b1);
    exp_prev = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      step(tbl[i].gin, tbl[i].egray, tbl[i].ebin, tbl[i].echg);
    end
    chk("tbl_err", gray_err, 1'b0);

    // Full walk and wrap back to zero
    for (int i = 4; i <= 32; i++) begin
      b = 5'(i % 32);
      g = b ^ (b >> 1);
      step(g, g, b, 1'b1);
    end
    chk("wrap_err", gray_err, 1'b0);
    chk("wrap_cnt", err_count, 2'd0);

    // Single multi-bit jump
    ptr_gray_in = 5'b00111;
    tick();
    tick();
    tick();
    chk("viol_err", gray_err, 1'b1);
    chk("viol_cnt", err_count, 2'd1);
`ifdef SYNC_GRAY_HOLD_EN
    chk("viol_gray", ptr_gray_sync, 5'b00000);
    chk("viol_chg", ptr_changed, 1'b0);
`else
    chk("viol_gray", ptr_gray_sync, 5'b00111);
    chk("viol_bin", ptr_bin_sync, 5'b00101);
    chk("viol_chg", ptr_changed, 1'b1);
`endif
    tick();

    // Clear, then saturate
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", gray_err, 1'b0);
    chk("clr_cnt", err_count, 2'd0);
    for (int i = 0; i < 5; i++) begin
      ptr_gray_in = (i % 2 == 0) ? 5'b00000 : 5'b00111;
      tick();
      tick();
      tick();
      chk("sat_step_cnt", err_count, (i < 3) ? 32'(i + 1) : 32'd3);
      tick();
    end
    chk("sat_cnt", err_count, 2'd3);
    chk("sat_err", gray_err, 1'b1);

    // Clear colliding with a violation: violation wins, count restarts at one
    ptr_gray_in = 5'b00111;
    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("coll_err", gray_err, 1'b1);
    chk("coll_cnt", err_count, 2'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr2_err", gray_err, 1'b0);
    chk("clr2_cnt", err_count, 2'd0);

    // Reset while a change strobe is high
    ptr_gray_in = 5'b00101;
    tick();
    tick();
    tick();
    chk("mid_chg", ptr_changed, 1'b1);
    chk("mid_gray", ptr_gray_sync, 5'b00101);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_gray", ptr_gray_sync, 5'b0);
    chk("arst_bin", ptr_bin_sync, 5'b0);
    chk("arst_chg", ptr_changed, 1'b0);
    chk("arst_valid", sync_valid, 1'b0);
    tick();
    rst = 1'b0;
    ptr_gray_in = 5'b00001;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("rewarm_valid", sync_valid, (e == 3) ? 1'b1 : 1'b0);
      chk("rewarm_chg", ptr_changed, 1'b0);
    end
    chk("rewarm_gray", ptr_gray_sync, 5'b00001);
    chk("rewarm_err", gray_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
